serial_addsub_unit: RTL and testbench

- Bit-serial N-bit adder/subtractor that consumes the single-bit add/sub cell (addsub) and a carry flop to perform one full-width operation over WIDTH cycles.
- Sits directly downstream of the 1-bit add/sub cell: it feeds that cell one operand bit pair per cycle and collects its sumdiff/cout outputs into a result shift register.
- Provides a start/done handshake toward the datapath controller.

---
 rtl/serial_addsub_pkg.sv | 15 +
 rtl/serial_addsub_bit.sv | 42 ++++
 rtl/serial_addsub_unit.sv | 133 +++++++++++++
 tb/tb_serial_addsub_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/sub unit: FSM encoding
// and the operation-counter width helper.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_addsub_bit.sv
// One add/sub cell plus its carry flop; the carry is preloaded with
// the initial cin on load and advanced on every enabled cycle.
module serial_addsub_bit (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic cin_init,
   input  logic en,
   input  logic op,
   input  logic a_i,
   input  logic b_i,
   output logic sumdiff,
   output logic cin,
   output logic cout
);

   logic carry_q;
   logic carry_d;
   logic bx;

   // Subtract is a + ~b + 1; the +1 arrives through the preloaded carry.
   assign bx      = b_i ^ op;
   assign sumdiff = a_i ^ bx ^ carry_q;
   assign cout    = (a_i & bx) | (carry_q & (a_i ^ bx));
   assign cin     = carry_q;

   always_comb begin
      carry_d = carry_q;
      if (load)
         carry_d = cin_init;
      else if (en)
         carry_d = cout;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         carry_q <= 1'b0;
      else
         carry_q <= carry_d;
   end

endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial WIDTH-bit adder/subtractor with start/done handshake.
// Optional running accumulate via SERIAL_ADDSUB_UNIT_ACCUM_EN.
module serial_addsub_unit
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             addsub,
`ifdef SERIAL_ADDSUB_UNIT_ACCUM_EN
   input  logic             accum,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-2:0] sh_q, sh_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]    count_q, count_d;
   logic             op_q, op_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             accept;
   logic             bit_en;
   logic             bit_sum;
   logic             bit_cin;
   logic             bit_cout;
   logic [WIDTH-1:0] a_src;

`ifdef SERIAL_ADDSUB_UNIT_ACCUM_EN
   assign a_src = accum ? result_q : a;
`else
   assign a_src = a;
`endif

   assign accept = start && (state_q == IDLE || state_q == DONE);

   serial_addsub_bit u_bit (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .cin_init (addsub),
      .en       (bit_en),
      .op       (op_q),
      .a_i      (sa_q[0]),
      .b_i      (sb_q[0]),
      .sumdiff  (bit_sum),
      .cin      (bit_cin),
      .cout     (bit_cout)
   );

   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      sh_d     = sh_q;
      result_d = result_q;
      count_d  = count_q;
      op_d     = op_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      bit_en   = 1'b0;
      unique case (state_q)
         RUN: begin
            bit_en         = 1'b1;
            sa_d           = sa_q >> 1;
            sb_d           = sb_q >> 1;
            sh_d           = sh_q >> 1;
            sh_d[WIDTH-2]  = bit_sum;
            count_d        = count_q + 1'b1;
            // Last bit: publish the whole word at once.
            if (count_q == CW'(WIDTH - 1)) begin
               result_d = {bit_sum, sh_q};
               cout_d   = bit_cout;
               ovf_d    = bit_cin ^ bit_cout;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (accept) begin
         sa_d    = a_src;
         sb_d    = b;
         op_d    = addsub;
         count_d = '0;
         state_d = RUN;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         sh_q     <= '0;
         result_q <= '0;
         count_q  <= '0;
         op_q     <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         sh_q     <= sh_d;
         result_q <= result_d;
         count_q  <= count_d;
         op_q     <= op_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);
   assign result   = result_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed self-checking bench for serial_addsub_unit (WIDTH=8).
module tb_serial_addsub_unit;

   logic       clk;
   logic       reset;
   logic       start;
   logic       addsub;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       cout;
   logic       overflow;
`ifdef SERIAL_ADDSUB_UNIT_ACCUM_EN
   logic       accum;
`endif

   int errors;
   int checks;
   int edges;
   int nbusy;

   serial_addsub_unit #(.WIDTH(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .addsub   (addsub),
`ifdef SERIAL_ADDSUB_UNIT_ACCUM_EN
      .accum    (accum),
`endif
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for done; counts edges and busy-high cycles.
   task automatic wait_done(output int ne, output int nb);
      ne = 0;
      nb = 0;
      while (!done && ne < 40) begin
         if (busy) nb++;
         @(posedge clk);
         #1;
         ne++;
      end
      checks++;
      assert (done === 1'b1) else begin
         errors++;
         $error("FAIL timeout: done=%b after %0d edges", done, ne);
      end
   endtask

   task automatic accept_op(input logic [7:0] ta, input logic [7:0] tb_,
                            input logic op);
      @(negedge clk);
      start  = 1'b1;
      a      = ta;
      b      = tb_;
      addsub = op;
      @(posedge clk);
      #1;
      start  = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [7:0] ta,
                         input logic [7:0] tb_, input logic op,
                         input logic [7:0] er, input logic ec,
                         input logic eo);
      int ne;
      int nb;
      accept_op(ta, tb_, op);
      wait_done(ne, nb);
      chk({tag, "_res"}, 32'(result), 32'(er));
      chk({tag, "_cout"}, 32'(cout), 32'(ec));
      chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      start  = 1'b0;
      addsub = 1'b0;
      a      = '0;
      b      = '0;
`ifdef SERIAL_ADDSUB_UNIT_ACCUM_EN
      accum  = 1'b0;
`endif
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_res", 32'(result), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // 1: add with latency and busy-width checks
      accept_op(8'h35, 8'h4A, 1'b0);
      chk("t1_busy0", 32'(busy), 32'd1);
      wait_done(edges, nbusy);
      chk("t1_edges", 32'(edges), 32'd8);
      chk("t1_nbusy", 32'(nbusy), 32'd8);
      chk("t1_busy_done", 32'(busy), 32'd0);
      chk("t1_res", 32'(result), 32'h7F);
      chk("t1_cout", 32'(cout), 32'd0);
      chk("t1_ovf", 32'(overflow), 32'd0);
      @(posedge clk);
      #1;
      chk("t1_done_pulse", 32'(done), 32'd0);
      chk("t1_hold", 32'(result), 32'h7F);

      // 2, 3: subtract and overflow/wrap corners
      run_op("sub1", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0);
      run_op("sub2", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
      run_op("ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      run_op("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op("sub3", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

      // 4: start during RUN is ignored
      accept_op(8'h01, 8'h02, 1'b0);
      @(posedge clk);
      @(negedge clk);
      start  = 1'b1;
      a      = 8'hAA;
      b      = 8'h55;
      addsub = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      wait_done(edges, nbusy);
      chk("t4_edges", 32'(edges + 2), 32'd8);
      chk("t4_res", 32'(result), 32'h03);
      @(posedge clk);
      #1;
      chk("t4_idle", 32'(busy), 32'd0);

      // 5: asynchronous reset mid-RUN
      accept_op(8'hF0, 8'hF0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_res", 32'(result), 32'd0);
      chk("t5_cout", 32'(cout), 32'd0);
      chk("t5_ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_op("t5_after", 8'h20, 8'h22, 1'b0, 8'h42, 1'b0, 1'b0);

      // 6: back-to-back with start held through DONE
      @(negedge clk);
      start  = 1'b1;
      a      = 8'h05;
      b      = 8'h03;
      addsub = 1'b0;
      @(posedge clk);
      #1;
      a = 8'h11;
      b = 8'h22;
      wait_done(edges, nbusy);
      chk("t6_res1", 32'(result), 32'h08);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("t6_busy2", 32'(busy), 32'd1);
      wait_done(edges, nbusy);
      chk("t6_gap", 32'(edges + 1), 32'd9);
      chk("t6_res2", 32'(result), 32'h33);

`ifdef SERIAL_ADDSUB_UNIT_ACCUM_EN
      run_op("acc_pre", 8'h08, 8'h08, 1'b0, 8'h10, 1'b0, 1'b0);
      @(negedge clk);
      accum = 1'b1;
      run_op("acc", 8'hFF, 8'h05, 1'b0, 8'h15, 1'b0, 1'b0);
      accum = 1'b0;
`endif

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
